// File: rtl/inst_fetch_seq.sv
// Instruction fetch / sequencing front end for the cube-solver core.
// Drives pc to the instruction ROM, latches the returned word into the
// instruction register, resolves JMP/JNZ internally and issues every other
// instruction to the datapath over a valid/ready handshake. A JMP whose
// target equals its own address is the terminal self-loop and halts.
// Optional watchdog: define FETCH_WDOG_EN to abort into HALT (wdog_err=1)
// after WDOG_LIMIT issue exits since the last start/reset.
module inst_fetch_seq #(
  parameter logic [7:0]  RESET_PC   = 8'd0,
  parameter logic [15:0] WDOG_LIMIT = 16'd4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  pc,
  input  logic [15:0] op,
  input  logic        flag,
  output logic        exec_valid,
  input  logic        exec_ready,
  output logic [3:0]  opcode,
  output logic [3:0]  dst,
  output logic [3:0]  src,
  output logic [3:0]  imm4,
  output logic [7:0]  imm8,
  output logic        busy,
  output logic        halted,
  output logic        wdog_err
);

  // Branch opcodes of the core's instruction set
  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_JNZ = 4'hF;

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

  state_t      state, state_nx;
  logic [7:0]  pc_nx;
  logic [15:0] ir;
  logic        is_jmp, is_jnz;
  logic        issue_exit;
  logic        wdog_hit;

  assign is_jmp = (ir[15:12] == OP_JMP);
  assign is_jnz = (ir[15:12] == OP_JNZ);

  // Field outputs always mirror the instruction register
  assign opcode = ir[15:12];
  assign dst    = ir[11:8];
  assign src    = ir[7:4];
  assign imm4   = ir[3:0];
  assign imm8   = ir[7:0];

  assign exec_valid = (state == ISSUE) && !is_jmp && !is_jnz;
  assign busy       = (state == FETCH) || (state == ISSUE);
  assign halted     = (state == HALT);

  // Next-state, next-pc and issue-exit decode
  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    issue_exit = 1'b0;
    unique case (state)
      IDLE, HALT: begin
        if (start) begin
          pc_nx    = RESET_PC;
          state_nx = FETCH;
        end
      end
      FETCH: state_nx = ISSUE;
      ISSUE: begin
        if (is_jmp) begin
          issue_exit = 1'b1;
          if (ir[7:0] == pc) begin
            state_nx = HALT;
          end else begin
            pc_nx    = ir[7:0];
            state_nx = FETCH;
          end
        end else if (is_jnz) begin
          issue_exit = 1'b1;
          pc_nx      = flag ? ir[7:0] : pc + 8'd1;
          state_nx   = FETCH;
        end else if (exec_ready) begin
          issue_exit = 1'b1;
          pc_nx      = pc + 8'd1;
          state_nx   = FETCH;
        end
        // The watchdog overrides the normal successor; pc still advances
        if (issue_exit && wdog_hit) state_nx = HALT;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, pc and instruction register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (state == FETCH) ir <= op;
    end
  end

`ifdef FETCH_WDOG_EN
  logic [15:0] wdog_cnt;
  logic        start_go;

  assign start_go = start && ((state == IDLE) || (state == HALT));
  assign wdog_hit = ((wdog_cnt + 16'd1) == WDOG_LIMIT);

  // Issue-exit budget counter and sticky abort flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else if (start_go) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else if (issue_exit) begin
      wdog_cnt <= wdog_cnt + 16'd1;
      if (wdog_hit) wdog_err <= 1'b1;
    end
  end
`else
  logic unused_wdog_limit;

  assign wdog_hit          = 1'b0;
  assign wdog_err          = 1'b0;
  assign unused_wdog_limit = ^WDOG_LIMIT;
`endif

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Bench for inst_fetch_seq: directed scenarios with literal expectations
// followed by randomized ROM/handshake/flag/start/reset traffic, all checked
// every cycle against an instruction-level reference model.
module tb_inst_fetch_seq;

  localparam logic [15:0] WDOG     = 16'd10;
  localparam logic [3:0]  OP_COPY  = 4'h1;
  localparam logic [3:0]  OP_ADD   = 4'h2;
  localparam logic [3:0]  OP_CHECK = 4'h7;
  localparam logic [3:0]  OP_JMP   = 4'hE;
  localparam logic [3:0]  OP_JNZ   = 4'hF;

  logic        clk = 1'b0;
  logic        rst, start, flag, exec_ready;
  logic [7:0]  pc, imm8;
  logic [15:0] op;
  logic        exec_valid, busy, halted, wdog_err;
  logic [3:0]  opcode, dst, src, imm4;
  logic [15:0] rom [256];

  assign op = rom[pc];

  inst_fetch_seq #(.RESET_PC(8'd0), .WDOG_LIMIT(WDOG)) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .op(op), .flag(flag),
    .exec_valid(exec_valid), .exec_ready(exec_ready), .opcode(opcode),
    .dst(dst), .src(src), .imm4(imm4), .imm8(imm8), .busy(busy),
    .halted(halted), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 fetching, 2 issuing, 3 halted
  int          m_mode, m_pc, m_cnt, m_tgt, m_nxt;
  bit          m_done, m_werr;
  logic [15:0] m_ir;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_pc = 0; m_ir = '0; m_cnt = 0; m_werr = 1'b0;
    end else begin
      case (m_mode)
        0, 3: if (start) begin
          m_mode = 1; m_pc = 0; m_cnt = 0; m_werr = 1'b0;
        end
        1: begin
          m_ir = rom[m_pc];
          m_mode = 2;
        end
        default: begin
          m_tgt  = int'(m_ir[7:0]);
          m_done = 1'b1;
          if (m_ir[15:12] == OP_JMP)      m_nxt = (m_tgt == m_pc) ? -1 : m_tgt;
          else if (m_ir[15:12] == OP_JNZ) m_nxt = flag ? m_tgt : (m_pc + 1) % 256;
          else if (exec_ready)            m_nxt = (m_pc + 1) % 256;
          else                            m_done = 1'b0;
          if (m_done) begin
`ifdef FETCH_WDOG_EN
            m_cnt++;
            if (m_cnt == int'(WDOG)) m_werr = 1'b1;
`endif
            if (m_nxt >= 0) m_pc = m_nxt;
            m_mode = (m_nxt < 0 || m_werr) ? 3 : 1;
          end
        end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model
  logic [63:0] exp_v, act_v;
  bit          m_ev;
  always begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      m_ev  = (m_mode == 2) && (m_ir[15:12] != OP_JMP) && (m_ir[15:12] != OP_JNZ);
      exp_v = {28'd0, 8'(m_pc), m_ev, (m_mode == 1 || m_mode == 2), (m_mode == 3),
               m_werr, m_ir};
      act_v = {28'd0, pc, exec_valid, busy, halted, wdog_err, opcode, dst, src, imm4};
      chk("cycle", act_v, exp_v);
      chk("imm8", {56'd0, imm8}, {56'd0, m_ir[7:0]});
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input int lim, input string nm);
    int n = 0;
    while (!halted && n < lim) begin @(negedge clk); n++; end
    chk(nm, {63'd0, halted}, 64'd1);
  endtask

  task automatic wait_valid(input int lim, input string nm);
    int n = 0;
    while (!exec_valid && n < lim) begin @(negedge clk); n++; end
    chk(nm, {63'd0, exec_valid}, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; flag = 1'b0; exec_ready = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = {OP_JMP, 4'h0, 8'(i)};
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_pc", {56'd0, pc}, 64'd0);
    chk("rst_status", {60'd0, exec_valid, busy, halted, wdog_err}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // COPY at pc 0: valid in second cycle after start, pc=1 after accept
    rom[0] = {OP_COPY, 4'h3, 4'h1, 4'h0};
    exec_ready = 1'b1;
    pulse_start();
    chk("copy_fetch", {62'd0, busy, exec_valid}, 64'd2);
    @(negedge clk);
    chk("copy_issue", {51'd0, exec_valid, opcode, dst, src}, {51'd0, 1'b1, OP_COPY, 4'h3, 4'h1});
    @(negedge clk);
    chk("copy_pc", {55'd0, exec_valid, pc}, 64'd1);
    wait_halt(10, "copy_halt");

    // Backpressure on ADD at pc 7
    rom[0] = {OP_JMP, 4'h0, 8'd7};
    rom[7] = {OP_ADD, 4'h5, 4'h6, 4'h2};
    rom[8] = {OP_JMP, 4'h0, 8'd12};
    rom[12] = {OP_CHECK, 12'h000};
    rom[13] = {OP_JNZ, 4'h0, 8'd28};
    exec_ready = 1'b0;
    flag = 1'b1;
    pulse_start();
    wait_valid(20, "bp_valid");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold", {43'd0, exec_valid, opcode, dst, src, pc},
          {43'd0, 1'b1, OP_ADD, 4'h5, 4'h6, 8'd7});
    end
    exec_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept", {55'd0, exec_valid, pc}, 64'd8);

    // JNZ taken (flag=1) lands on 28, not taken lands on 14
    wait_halt(30, "jnz1_halt");
    chk("jnz1_pc", {56'd0, pc}, 64'd28);
    flag = 1'b0;
    rom[0] = {OP_JMP, 4'h0, 8'd12};
    pulse_start();
    wait_halt(30, "jnz0_halt");
    chk("jnz0_pc", {56'd0, pc}, 64'd14);

    // Terminal self-jump at 77
    rom[0] = {OP_JMP, 4'h0, 8'd77};
    pulse_start();
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("fin_issue", {55'd0, halted, pc}, 64'd77);
    @(negedge clk);
    chk("fin_halt", {55'd0, halted, pc}, {55'd0, 1'b1, 8'd77});
    repeat (3) @(negedge clk);
    chk("fin_hold", {55'd0, halted, pc}, {55'd0, 1'b1, 8'd77});
    pulse_start();
    chk("fin_restart", {55'd0, halted, pc}, 64'd0);
    wait_halt(10, "fin_rehalt");

    // pc wrap 255 -> 0, then asynchronous reset while valid
    rom[0] = {OP_JMP, 4'h0, 8'd255};
    rom[255] = {OP_COPY, 4'h2, 4'h3, 4'h0};
    pulse_start();
    wait_valid(20, "wrap_valid");
    chk("wrap_pc255", {56'd0, pc}, 64'd255);
    @(negedge clk);
    chk("wrap_pc0", {55'd0, exec_valid, pc}, 64'd0);
    exec_ready = 1'b0;
    wait_valid(20, "rst_valid");
    #2 rst = 1'b1;
    #1 chk("rst_async", {52'd0, exec_valid, busy, halted, pc}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Jump ping-pong: watchdog aborts, or runs forever without it
    rom[0] = {OP_JMP, 4'h0, 8'd1};
    rom[1] = {OP_JMP, 4'h0, 8'd0};
    pulse_start();
`ifdef FETCH_WDOG_EN
    wait_halt(100, "wdog_halt");
    chk("wdog_err", {55'd0, wdog_err, pc}, {55'd0, 1'b1, 8'd0});
    pulse_start();
    chk("wdog_clear", {63'd0, wdog_err}, 64'd0);
`else
    repeat (100) @(negedge clk);
    chk("nowdog_run", {62'd0, halted, wdog_err}, 64'd0);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rom[i][7:0] = 8'(i);
    end
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      start      = ($urandom_range(0, 15) == 0);
      exec_ready = ($urandom_range(0, 2) != 0);
      flag       = 1'($urandom);
      rst        = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_fetch_seq.md
Name: inst_fetch_seq

Overview:
- Instruction fetch and sequencing front end for the cube-solver core; it is the consumer side of the instruction ROM.
- Drives `pc` to the ROM, samples the returned 16-bit `op` into an instruction register and resolves JMP/JNZ internally.
- Issues every other instruction to the datapath over a valid/ready handshake.
- Detects the terminal self-jump and halts.

Parameters:
- RESET_PC, 8'd0, PC value loaded at reset and on start.
- WDOG_LIMIT, 16'd4096, issued-instruction budget before watchdog abort (only with FETCH_WDOG_EN).

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins execution from RESET_PC when IDLE or HALT
- pc  out  8  ROM address
- op  in  16  ROM data; combinational from pc, valid in the same cycle
- flag  in  1  datapath nonzero flag from the most recently completed CHECK/COMP
- exec_valid  out  1  decoded instruction presented to datapath
- exec_ready  in  1  datapath accepts/completes presented instruction
- opcode  out  4  op[15:12]
- dst  out  4  op[11:8]
- src  out  4  op[7:4]
- imm4  out  4  op[3:0]
- imm8  out  8  op[7:0]
- busy  out  1  high in FETCH/ISSUE
- halted  out  1  high in HALT
- wdog_err  out  1  watchdog abort (0 when feature compiled out)

Behaviour:
- Clocking and reset
  - Single clock; reset is asynchronous and active-high.
  - Reset values: state=IDLE, pc=RESET_PC, IR=16'h0, exec_valid=0, busy=0, halted=0, wdog_err=0.
  - rst asserted mid-operation aborts the current instruction immediately; a pending exec_valid drops in the same reset.
- State machine (IDLE, FETCH, ISSUE, HALT)
  - IDLE: wait for start; on start, pc<=RESET_PC and go to FETCH.
  - FETCH: one cycle; IR<=op at the clock edge; go to ISSUE.
  - ISSUE with IR opcode == JMP (def.h):
    - if imm8 == pc, go to HALT (FIN self-loop);
    - otherwise pc<=imm8 and go to FETCH;
    - exec_valid stays 0.
  - ISSUE with IR opcode == JNZ:
    - flag is sampled in this cycle;
    - pc<=flag ? imm8 : pc+1, then go to FETCH;
    - exec_valid stays 0.
  - ISSUE with any other opcode:
    - exec_valid=1; opcode/dst/src/imm4/imm8 come from the IR and are stable while exec_valid=1;
    - on exec_valid&&exec_ready, pc<=pc+1 and go to FETCH;
    - exec_valid may not drop before acceptance.
  - HALT: outputs hold and halted=1; start restarts (pc<=RESET_PC, halted<=0, FETCH).
- Field outputs: always reflect the IR regardless of state. Datapath must ignore them when exec_valid=0.
- Latency
  - Datapath instruction: 1 fetch cycle + 1 issue cycle minimum (exec_ready=1).
  - JMP/JNZ: 2 cycles each.
- Flag hazard: datapath guarantees flag is updated by the edge at which it accepts CHECK/COMP. The following FETCH cycle provides the required slack, so JNZ immediately after CHECK/COMP is legal.
- Arithmetic
  - pc+1 is 8-bit modulo: 255 wraps to 0.
  - A JMP target of 0 from pc 0 counts as a self-jump and halts.
- start: ignored in FETCH/ISSUE; a start during reset is ignored.

Optional Feature:
- Macro: FETCH_WDOG_EN.
- With the macro:
  - a 16-bit counter clears on start/reset;
  - it increments on every ISSUE exit, including JMP/JNZ;
  - when it reaches WDOG_LIMIT, the block enters HALT with wdog_err=1;
  - wdog_err clears on start or reset.
- Without the macro: no counter; wdog_err tied 0; WDOG_LIMIT unused.

Test Plan:
- Reset/start:
  - rst pulse → pc=0, exec_valid=0, halted=0.
  - start with ROM[0]={COPY,TMP_BLUE_ADDR,BLUE_ADDR,0} and exec_ready=1 → exec_valid high in cycle 2 with opcode=COPY, dst=TMP_BLUE_ADDR, src=BLUE_ADDR; pc=1 next cycle.
- Backpressure: exec_ready held 0 for 5 cycles on ADD at pc 7 → exec_valid and fields stable for 5 cycles; pc stays 7; pc=8 only after the ready cycle.
- JNZ both ways: CHECK at pc 12 then JNZ→28 at pc 13.
  - flag=1 → pc becomes 28.
  - flag=0 → pc becomes 14.
  - exec_valid never asserted for JNZ.
- Halt: JMP imm8=77 at pc 77 → halted=1 two cycles after fetch; pc frozen at 77; a later start → pc=0, halted=0.
- Wrap/reset mid-op:
  - ROM[255]=COPY accepted → pc wraps to 0.
  - rst asserted while exec_valid=1 → exec_valid=0 asynchronously; state IDLE.
- Watchdog (FETCH_WDOG_EN, WDOG_LIMIT=10): ROM[0]=JMP 1, ROM[1]=JMP 0 → HALT with wdog_err=1 after 10 issued jumps; without the macro the loop runs indefinitely with wdog_err=0.
